// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// calc_seq_ctrl : signed keypad calculator sequencer driving a shared
//                 arithmetic unit over a start/done handshake.
// Revision 1.0
// ============================================================================
module calc_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT    = 64,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              key_valid,
  input  logic [3:0]        key_digit,
  input  logic              neg_valid,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic              eq_valid,
  input  logic              clr,
  output logic              unit_start,
  output logic [1:0]        unit_op,
  output logic [WIDTH-1:0]  unit_a,
  output logic [WIDTH-1:0]  unit_b,
  input  logic              unit_done,
  input  logic [WIDTH-1:0]  unit_result,
  input  logic              unit_ovf,
  output logic [WIDTH-1:0]  display,
  output logic              complete,
  output logic              error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ACC_W = WIDTH + 5;
  localparam logic [ACC_W-1:0]  MAX_MAG = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [1:0]        OP_DIV  = 2'b11;
  localparam logic [ADDR_W-1:0] ADDR_A  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_B  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_R  = ADDR_W'(2);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t            r_state, w_state;
  logic [WIDTH-1:0]  r_a_mag, w_a_mag, r_b_mag, w_b_mag;
  logic              r_a_neg, w_a_neg, r_b_neg, w_b_neg;
  logic [CNT_W-1:0]  r_a_cnt, w_a_cnt, r_b_cnt, w_b_cnt;
  logic [1:0]        r_op, w_op;
  logic [TMO_W-1:0]  r_tcnt, w_tcnt;
  logic [WIDTH-1:0]  r_result, w_result;
  logic [WIDTH-1:0]  r_display, w_display;
  logic              r_complete, w_complete;
  logic              r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata, w_mem_wdata;

  logic              w_in_b;
  logic [WIDTH-1:0]  w_cur_mag;
  logic              w_cur_neg;
  logic [CNT_W-1:0]  w_cur_cnt;
  logic [ACC_W-1:0]  w_acc;
  logic              w_digit_ok;
  logic              w_div_zero;
  logic              w_upd;
  logic [WIDTH-1:0]  w_upd_mag;
  logic              w_upd_neg;
  logic [CNT_W-1:0]  w_upd_cnt;
  logic [WIDTH-1:0]  w_upd_val;

  function automatic logic [WIDTH-1:0] to_signed(input logic neg, input logic [WIDTH-1:0] mag);
    return neg ? ((~mag) + WIDTH'(1)) : mag;
  endfunction

  // Operands are kept as sign + magnitude so -0 naturally shows as 0.
  assign w_in_b     = (r_state == S_ENTER_B);
  assign w_cur_mag  = w_in_b ? r_b_mag : r_a_mag;
  assign w_cur_neg  = w_in_b ? r_b_neg : r_a_neg;
  assign w_cur_cnt  = w_in_b ? r_b_cnt : r_a_cnt;
  assign w_acc      = ACC_W'(w_cur_mag) * ACC_W'(10) + ACC_W'(key_digit);
  assign w_digit_ok = (key_digit <= 4'd9) && (w_cur_cnt < CNT_MAX) && (w_acc <= MAX_MAG);
  assign w_div_zero = (r_op == OP_DIV) && (r_b_mag == '0);
  assign w_upd_val  = to_signed(w_upd_neg, w_upd_mag);

  always_comb begin
    w_state     = r_state;
    w_a_mag     = r_a_mag;
    w_a_neg     = r_a_neg;
    w_a_cnt     = r_a_cnt;
    w_b_mag     = r_b_mag;
    w_b_neg     = r_b_neg;
    w_b_cnt     = r_b_cnt;
    w_op        = r_op;
    w_tcnt      = r_tcnt;
    w_result    = r_result;
    w_display   = r_display;
    w_complete  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_upd       = 1'b0;
    w_upd_mag   = w_cur_mag;
    w_upd_neg   = w_cur_neg;
    w_upd_cnt   = w_cur_cnt;

    if (clr) begin
      w_state   = S_ENTER_A;
      w_a_mag   = '0;
      w_a_neg   = 1'b0;
      w_a_cnt   = '0;
      w_b_mag   = '0;
      w_b_neg   = 1'b0;
      w_b_cnt   = '0;
      w_op      = '0;
      w_tcnt    = '0;
      w_display = '0;
    end else begin
      case (r_state)
        S_ENTER_A, S_ENTER_B: begin
          if (eq_valid) begin
            if (w_in_b) w_state = S_ISSUE;
          end else if (op_valid) begin
            if (!w_in_b) begin
              w_op    = op_code;
              w_state = S_ENTER_B;
            end else if (r_b_cnt == '0) begin
              w_op = op_code;
            end
          end else if (neg_valid) begin
            w_upd     = 1'b1;
            w_upd_neg = ~w_cur_neg;
          end else if (key_valid && w_digit_ok) begin
            w_upd     = 1'b1;
            w_upd_mag = w_acc[WIDTH-1:0];
            w_upd_cnt = w_cur_cnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (w_div_zero) begin
            w_state   = S_ERR;
            w_display = '0;
          end else begin
            w_state = S_WAIT;
            w_tcnt  = '0;
          end
        end
        S_WAIT: begin
          w_tcnt = r_tcnt + TMO_W'(1);
          if (unit_done) begin
            w_result = unit_result;
            if (unit_ovf) begin
              w_state   = S_ERR;
              w_display = '0;
            end else begin
              w_state     = S_SHOW;
              w_complete  = 1'b1;
              w_display   = unit_result;
              w_mem_we    = 1'b1;
              w_mem_addr  = ADDR_R;
              w_mem_wdata = unit_result;
            end
          end else if (w_tcnt == TMO_LIM) begin
            w_state   = S_ERR;
            w_display = '0;
          end
        end
        S_SHOW: begin
          // eq and neg are swallowed here but still mask lower-priority strobes.
          if (!eq_valid) begin
            if (op_valid) begin
              w_a_neg = r_result[WIDTH-1];
              w_a_mag = to_signed(r_result[WIDTH-1], r_result);
              w_a_cnt = CNT_MAX;
              w_b_mag = '0;
              w_b_neg = 1'b0;
              w_b_cnt = '0;
              w_op    = op_code;
              w_state = S_ENTER_B;
            end else if (!neg_valid && key_valid && (key_digit <= 4'd9)) begin
              w_b_mag   = '0;
              w_b_neg   = 1'b0;
              w_b_cnt   = '0;
              w_upd     = 1'b1;
              w_upd_mag = WIDTH'(key_digit);
              w_upd_neg = 1'b0;
              w_upd_cnt = CNT_W'(1);
              w_state   = S_ENTER_A;
            end
          end
        end
        S_ERR: begin
          w_display = '0;
        end
        default: begin
          w_state = S_ENTER_A;
        end
      endcase

      if (w_upd) begin
        if (w_in_b) begin
          w_b_mag = w_upd_mag;
          w_b_neg = w_upd_neg;
          w_b_cnt = w_upd_cnt;
        end else begin
          w_a_mag = w_upd_mag;
          w_a_neg = w_upd_neg;
          w_a_cnt = w_upd_cnt;
        end
        w_display   = w_upd_val;
        w_mem_we    = 1'b1;
        w_mem_addr  = w_in_b ? ADDR_B : ADDR_A;
        w_mem_wdata = w_upd_val;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_ENTER_A;
      r_a_mag     <= '0;
      r_a_neg     <= 1'b0;
      r_a_cnt     <= '0;
      r_b_mag     <= '0;
      r_b_neg     <= 1'b0;
      r_b_cnt     <= '0;
      r_op        <= '0;
      r_tcnt      <= '0;
      r_result    <= '0;
      r_display   <= '0;
      r_complete  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state;
      r_a_mag     <= w_a_mag;
      r_a_neg     <= w_a_neg;
      r_a_cnt     <= w_a_cnt;
      r_b_mag     <= w_b_mag;
      r_b_neg     <= w_b_neg;
      r_b_cnt     <= w_b_cnt;
      r_op        <= w_op;
      r_tcnt      <= w_tcnt;
      r_result    <= w_result;
      r_display   <= w_display;
      r_complete  <= w_complete;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign unit_start = (r_state == S_ISSUE) && !w_div_zero;
  assign unit_op    = r_op;
  assign unit_a     = to_signed(r_a_neg, r_a_mag);
  assign unit_b     = to_signed(r_b_neg, r_b_mag);
  assign display    = r_display;
  assign complete   = r_complete;
  assign error      = (r_state == S_ERR);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// Scoreboard bench for calc_seq_ctrl: directed keypad sequences, scripted
// arithmetic unit, monitor checking memory writes, results and unit requests.
module tb_calc_seq_ctrl;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic              key_valid = 1'b0;
  logic [3:0]        key_digit = 4'd0;
  logic              neg_valid = 1'b0;
  logic              op_valid = 1'b0;
  logic [1:0]        op_code = 2'b00;
  logic              eq_valid = 1'b0;
  logic              clr = 1'b0;
  logic              unit_start;
  logic [1:0]        unit_op;
  logic [WIDTH-1:0]  unit_a, unit_b;
  logic              unit_done = 1'b0;
  logic [WIDTH-1:0]  unit_result = '0;
  logic              unit_ovf = 1'b0;
  logic [WIDTH-1:0]  display;
  logic              complete, error, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  calc_seq_ctrl #(.WIDTH(WIDTH), .MAX_DIGITS(5), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nRST(nRST), .key_valid(key_valid), .key_digit(key_digit),
    .neg_valid(neg_valid), .op_valid(op_valid), .op_code(op_code),
    .eq_valid(eq_valid), .clr(clr), .unit_start(unit_start), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
    .unit_result(unit_result), .unit_ovf(unit_ovf), .display(display),
    .complete(complete), .error(error), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W+WIDTH-1:0] mem_q[$];
  logic [WIDTH-1:0]        res_q[$];
  logic [2+2*WIDTH-1:0]    start_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, expected no event", name, act);
  endtask

  // Monitor: every DUT-presented event is matched against the scoreboard.
  always @(negedge clk) begin
    if (nRST) begin
      if (mem_we) begin
        if (mem_q.size() == 0) unexpected("mem_write", 64'({mem_addr, mem_wdata}));
        else check("mem_write", 64'({mem_addr, mem_wdata}), 64'(mem_q.pop_front()));
      end
      if (complete) begin
        if (res_q.size() == 0) unexpected("result", 64'(display));
        else check("result", 64'(display), 64'(res_q.pop_front()));
      end
      if (unit_start) begin
        if (start_q.size() == 0) unexpected("unit_req", 64'({unit_op, unit_a, unit_b}));
        else check("unit_req", 64'({unit_op, unit_a, unit_b}), 64'(start_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; tick(); key_valid = 1'b0;
  endtask

  task automatic press_neg();
    neg_valid = 1'b1; tick(); neg_valid = 1'b0;
  endtask

  task automatic press_op(input logic [1:0] c);
    op_valid = 1'b1; op_code = c; tick(); op_valid = 1'b0;
  endtask

  task automatic press_eq();
    eq_valid = 1'b1; tick(); eq_valid = 1'b0;
  endtask

  task automatic press_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic exp_mem(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    mem_q.push_back({a, d});
  endtask

  task automatic exp_start(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start_q.push_back({o, a, b});
  endtask

  // Called right after eq: the DUT must be in its request cycle now.
  task automatic run_unit(input logic [WIDTH-1:0] r, input logic ovf, input int delay);
    check("start_latency", 64'(unit_start), 64'd1);
    tick();
    repeat (delay) tick();
    unit_done = 1'b1; unit_result = r; unit_ovf = ovf;
    tick();
    unit_done = 1'b0; unit_ovf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_display", 64'(display), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_outputs", 64'({complete, mem_we, unit_start}), 64'd0);
    check("rst_operands", 64'({unit_a, unit_b}), 64'd0);
    nRST = 1'b1;
    tick();

    // 12 + 34 = 46
    exp_mem(0, 16'd1);  press_key(4'd1);
    exp_mem(0, 16'd12); press_key(4'd2);
    press_op(2'b00);
    exp_mem(1, 16'd3);  press_key(4'd3);
    exp_mem(1, 16'd34); press_key(4'd4);
    exp_start(2'b00, 16'd12, 16'd34);
    press_eq();
    res_q.push_back(16'd46); exp_mem(2, 16'd46);
    run_unit(16'd46, 1'b0, 3);
    check("show_display", 64'(display), 64'd46);

    // Chain: 46 - 6 = 40
    press_op(2'b01);
    exp_mem(1, 16'd6); press_key(4'd6);
    exp_start(2'b01, 16'd46, 16'd6);
    press_eq();
    res_q.push_back(16'd40); exp_mem(2, 16'd40);
    run_unit(16'd40, 1'b0, 1);

    // -5 * 7 = -35
    press_clr();
    check("clr_display", 64'(display), 64'd0);
    exp_mem(0, 16'd5);    press_key(4'd5);
    exp_mem(0, 16'hFFFB); press_neg();
    press_op(2'b10);
    exp_mem(1, 16'd7);    press_key(4'd7);
    exp_start(2'b10, 16'hFFFB, 16'd7);
    press_eq();
    res_q.push_back(16'hFFDD); exp_mem(2, 16'hFFDD);
    run_unit(16'hFFDD, 1'b0, 2);

    // Digit-count limit: 32767 accepted, sixth digit dropped; then overflow from the unit
    press_clr();
    exp_mem(0, 16'd3);     press_key(4'd3);
    exp_mem(0, 16'd32);    press_key(4'd2);
    exp_mem(0, 16'd327);   press_key(4'd7);
    exp_mem(0, 16'd3276);  press_key(4'd6);
    exp_mem(0, 16'd32767); press_key(4'd7);
    press_key(4'd8);
    press_op(2'b00);
    exp_mem(1, 16'd1); press_key(4'd1);
    exp_start(2'b00, 16'd32767, 16'd1);
    press_eq();
    run_unit(16'h8000, 1'b1, 1);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_display", 64'(display), 64'd0);

    // Magnitude limit: 32768 rejected, A stays 3276
    press_clr();
    check("clr_error", 64'(error), 64'd0);
    exp_mem(0, 16'd3);    press_key(4'd3);
    exp_mem(0, 16'd32);   press_key(4'd2);
    exp_mem(0, 16'd327);  press_key(4'd7);
    exp_mem(0, 16'd3276); press_key(4'd6);
    press_key(4'd8);
    press_key(4'd12);
    exp_mem(0, 16'hF334); press_neg();
    check("neg_display", 64'(display), 64'hF334);

    // Divide by zero: no request, error held until clr
    press_clr();
    exp_mem(0, 16'd9); press_key(4'd9);
    press_op(2'b11);
    press_eq();
    check("div0_no_start", 64'(unit_start), 64'd0);
    tick();
    check("div0_error", 64'(error), 64'd1);
    check("div0_display", 64'(display), 64'd0);
    press_key(4'd2);
    check("err_holds", 64'(error), 64'd1);
    press_clr();
    check("div0_clr_error", 64'(error), 64'd0);
    exp_mem(0, 16'd4); press_key(4'd4);

    // Timeout: ISSUE cycle plus TIMEOUT silent WAIT cycles
    press_clr();
    exp_mem(0, 16'd1); press_key(4'd1);
    press_op(2'b00);
    exp_mem(1, 16'd2); press_key(4'd2);
    exp_start(2'b00, 16'd1, 16'd2);
    press_eq();
    check("to_start", 64'(unit_start), 64'd1);
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TIMEOUT + 1));

    // clr during WAIT, late unit_done ignored
    press_clr();
    exp_mem(0, 16'd1); press_key(4'd1);
    press_op(2'b00);
    exp_mem(1, 16'd2); press_key(4'd2);
    exp_start(2'b00, 16'd1, 16'd2);
    press_eq();
    repeat (10) tick();
    press_clr();
    repeat (9) tick();
    unit_done = 1'b1; unit_result = 16'd99;
    tick();
    unit_done = 1'b0;
    tick();
    check("late_done_error", 64'(error), 64'd0);
    check("late_done_display", 64'(display), 64'd0);
    exp_mem(0, 16'd5); press_key(4'd5);

    // Coincident strobes: op beats digit, eq beats digit; digit from SHOW starts new A
    press_clr();
    op_valid = 1'b1; op_code = 2'b00; key_valid = 1'b1; key_digit = 4'd3;
    tick();
    op_valid = 1'b0; key_valid = 1'b0;
    exp_mem(1, 16'd2); press_key(4'd2);
    exp_start(2'b00, 16'd0, 16'd2);
    eq_valid = 1'b1; key_valid = 1'b1; key_digit = 4'd4;
    tick();
    eq_valid = 1'b0; key_valid = 1'b0;
    res_q.push_back(16'd7); exp_mem(2, 16'd7);
    run_unit(16'd7, 1'b0, 2);
    exp_mem(0, 16'd8); press_key(4'd8);

    // Reset during WAIT abandons the request
    press_op(2'b00);
    exp_mem(1, 16'd3); press_key(4'd3);
    exp_start(2'b00, 16'd8, 16'd3);
    press_eq();
    repeat (3) tick();
    #2 nRST = 1'b0;
    #1 check("rst_wait_display", 64'(display), 64'd0);
    check("rst_wait_operands", 64'({unit_a, unit_b}), 64'd0);
    tick();
    nRST = 1'b1;
    tick();
    unit_done = 1'b1; unit_result = 16'd11;
    tick();
    unit_done = 1'b0;
    exp_mem(0, 16'd7); press_key(4'd7);

    repeat (3) tick();
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
    check("start_q_drained", 64'(start_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
